// File: rtl/cpu_control_fsm.sv
// Multi-cycle control sequencer for the single-datapath CPU.
// Decodes one instruction at a time and drives every datapath select/strobe.
module cpu_control_fsm #(
    parameter bit IN_EDGE = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] inst,
    input  logic        zero,
    input  logic        of,
    input  logic        enter,
    output logic        halt,
    output logic        sreg,
    output logic        smux5,
    output logic [1:0]  smux16,
    output logic        smux32,
    output logic [2:0]  smuxPC,
    output logic [3:0]  salu,
    output logic        smem,
    output logic        sdisplay,
    output logic        smemtoreg,
    output logic        waiting_in,
    output logic        err,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        FETCH   = 3'd0,
        DECODE  = 3'd1,
        EXEC    = 3'd2,
        MEM     = 3'd3,
        WAIT_IN = 3'd4,
        COMMIT  = 3'd5,
        HALTED  = 3'd6
    } state_t;

    typedef struct packed {
        logic       smux5;
        logic [1:0] smux16;
        logic       smux32;
        logic [2:0] smuxpc;
        logic [3:0] salu;
        logic       m2r;
    } sel_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_IN   = 6'b011110;
    localparam logic [5:0] OP_OUT  = 6'b011111;
    localparam logic [5:0] OP_HLT  = 6'b111111;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_XOR = 6'b100110;
    localparam logic [5:0] F_NOR = 6'b100111;
    localparam logic [5:0] F_SLT = 6'b101010;
    localparam logic [5:0] F_SLL = 6'b000000;
    localparam logic [5:0] F_SRL = 6'b000010;
    localparam logic [5:0] F_JR  = 6'b001000;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_NOR  = 4'b0101;
    localparam logic [3:0] ALU_SLT  = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_PASS = 4'b1001;

    state_t     cur;
    sel_t       sel;
    sel_t       d_sel;
    logic [5:0] op;
    logic [5:0] fn;
    logic       d_legal;
    logic       d_write;
    logic       d_ovf;
    logic       d_lw;
    logic       d_sw;
    logic       d_in;
    logic       d_out;
    logic       d_hlt;
    logic       k_write;
    logic       k_ovf;
    logic       k_lw;
    logic       k_in;
    logic       k_hlt;
    logic       enter_q;
    logic       in_done;
    logic       go_commit;
    logic       ovf_hit;
    logic       unused;

    assign op     = inst[31:26];
    assign fn     = inst[5:0];
    assign unused = ^{zero, inst[25:6]};

    assign state      = cur;
    assign waiting_in = (cur == WAIT_IN);
    assign smux5      = sel.smux5;
    assign smux16     = sel.smux16;
    assign smux32     = sel.smux32;
    assign smuxPC     = sel.smuxpc;
    assign salu       = sel.salu;
    assign smemtoreg  = sel.m2r;

    // Input completion: a fresh press, or simply the button level.
    assign in_done = IN_EDGE ? (enter & ~enter_q) : enter;

    // Overflow only aborts the write of the signed-add/sub family.
    assign ovf_hit = k_ovf & of;

    // Every path that ends the execute phase converges on COMMIT.
    always_comb begin
        go_commit = 1'b0;
        case (cur)
            EXEC:    go_commit = ~k_lw & ~k_in & ~k_hlt;
            MEM:     go_commit = 1'b1;
            WAIT_IN: go_commit = in_done;
            default: go_commit = 1'b0;
        endcase
    end

    // Opcode/funct decode into select bundle and instruction class.
    always_comb begin
        d_sel   = '0;
        d_legal = 1'b0;
        d_write = 1'b0;
        d_ovf   = 1'b0;
        d_lw    = 1'b0;
        d_sw    = 1'b0;
        d_in    = 1'b0;
        d_out   = 1'b0;
        d_hlt   = 1'b0;
        unique case (op)
            OP_R: begin
                d_legal = 1'b1;
                d_write = 1'b1;
                unique case (fn)
                    F_ADD: begin
                        d_sel.salu = ALU_ADD;
                        d_ovf      = 1'b1;
                    end
                    F_SUB: begin
                        d_sel.salu = ALU_SUB;
                        d_ovf      = 1'b1;
                    end
                    F_AND: d_sel.salu = ALU_AND;
                    F_OR:  d_sel.salu = ALU_OR;
                    F_XOR: d_sel.salu = ALU_XOR;
                    F_NOR: d_sel.salu = ALU_NOR;
                    F_SLT: d_sel.salu = ALU_SLT;
                    F_SLL: d_sel.salu = ALU_SLL;
                    F_SRL: d_sel.salu = ALU_SRL;
                    F_JR: begin
                        d_write      = 1'b0;
                        d_sel.smuxpc = 3'b100;
                    end
                    default: begin
                        d_legal = 1'b0;
                        d_write = 1'b0;
                    end
                endcase
            end
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: begin
                d_legal      = 1'b1;
                d_write      = 1'b1;
                d_sel.smux5  = 1'b1;
                d_sel.smux32 = 1'b1;
                if (op == OP_ADDI) begin
                    d_sel.salu = ALU_ADD;
                    d_ovf      = 1'b1;
                end else if (op == OP_ANDI) begin
                    d_sel.salu = ALU_AND;
                end else if (op == OP_ORI) begin
                    d_sel.salu = ALU_OR;
                end else begin
                    d_sel.salu = ALU_SLT;
                end
            end
            OP_LW: begin
                d_legal      = 1'b1;
                d_write      = 1'b1;
                d_lw         = 1'b1;
                d_sel.smux5  = 1'b1;
                d_sel.smux32 = 1'b1;
                d_sel.salu   = ALU_ADD;
                d_sel.m2r    = 1'b1;
            end
            OP_SW: begin
                d_legal      = 1'b1;
                d_sw         = 1'b1;
                d_sel.smux5  = 1'b1;
                d_sel.smux32 = 1'b1;
                d_sel.salu   = ALU_ADD;
            end
            OP_BEQ, OP_BNE: begin
                d_legal      = 1'b1;
                d_sel.salu   = ALU_SUB;
                d_sel.smuxpc = (op == OP_BEQ) ? 3'b001 : 3'b010;
            end
            OP_J: begin
                d_legal      = 1'b1;
                d_sel.smuxpc = 3'b011;
            end
            OP_IN: begin
                d_legal      = 1'b1;
                d_write      = 1'b1;
                d_in         = 1'b1;
                d_sel.smux5  = 1'b1;
                d_sel.smux16 = 2'b01;
                d_sel.smux32 = 1'b1;
                d_sel.salu   = ALU_PASS;
            end
            OP_OUT: begin
                d_legal = 1'b1;
                d_out   = 1'b1;
            end
            OP_HLT: begin
                d_legal = 1'b1;
                d_hlt   = 1'b1;
            end
            default: d_legal = 1'b0;
        endcase
    end

    // Sequencer: state, sticky error, registered selects and strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur      <= FETCH;
            err      <= 1'b0;
            halt     <= 1'b1;
            sreg     <= 1'b0;
            smem     <= 1'b0;
            sdisplay <= 1'b0;
            sel      <= '0;
            k_write  <= 1'b0;
            k_ovf    <= 1'b0;
            k_lw     <= 1'b0;
            k_in     <= 1'b0;
            k_hlt    <= 1'b0;
            enter_q  <= 1'b0;
        end else begin
            enter_q  <= enter;
            halt     <= 1'b1;
            sreg     <= 1'b0;
            smem     <= 1'b0;
            sdisplay <= 1'b0;
            if (go_commit) begin
                cur  <= COMMIT;
                halt <= 1'b0;
                if (ovf_hit) begin
                    err <= 1'b1;
                end else begin
                    sreg <= k_write;
                end
            end else begin
                case (cur)
                    FETCH: cur <= DECODE;
                    DECODE: begin
                        if (!d_legal) begin
                            cur <= HALTED;
                            err <= 1'b1;
                        end else begin
                            cur      <= EXEC;
                            sel      <= d_sel;
                            k_write  <= d_write;
                            k_ovf    <= d_ovf;
                            k_lw     <= d_lw;
                            k_in     <= d_in;
                            k_hlt    <= d_hlt;
                            smem     <= d_sw;
                            sdisplay <= d_out;
                        end
                    end
                    EXEC: begin
                        if (k_lw) begin
                            cur <= MEM;
                        end else if (k_in) begin
                            cur <= WAIT_IN;
                        end else begin
                            cur <= HALTED;
                            sel <= '0;
                        end
                    end
                    COMMIT: begin
                        cur <= err ? HALTED : FETCH;
                        sel <= '0;
                    end
                    default: cur <= cur;
                endcase
            end
        end
    end

endmodule

// File: doc/cpu_control_fsm.md
Name: cpu_control_fsm

Overview:
- Multi-cycle control sequencer for the single-datapath CPU (PC, InstMem, RegBank, ALU, DataMem, MuxPC, display).
- Decodes the current instruction word and drives every datapath select and strobe: halt, sreg, smux5, smux16, smux32, smuxPC, salu, smem, sdisplay, smemtoreg.
- Sequences one instruction at a time through fetch/decode/execute/memory/commit.
- Adds a switch-input handshake and a sticky error/halt state.

Parameters:
- IN_EDGE, 1, 1 = IN completes on rising edge of enter; 0 = on enter level high.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- inst  input  32  instruction word from InstMem (valid from DECODE on)
- zero  input  1  ALU zero flag
- of  input  1  ALU overflow flag
- enter  input  1  user confirm button, already synchronised
- halt  output  1  PC hold (1 = hold)
- sreg  output  1  RegBank write strobe
- smux5  output  1  write-reg select: 0 = inst[15:11], 1 = inst[20:16]
- smux16  output  2  00 = immediate, 01 = switches, 10 = PC
- smux32  output  1  ALU B select: 0 = RegBank B, 1 = sign-extended value
- smuxPC  output  3  000 = PC+1, 001 = branch if zero, 010 = branch if !zero, 011 = jump imm, 100 = jump reg
- salu  output  4  0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 nor, 0110 slt, 0111 sll, 1000 srl, 1001 pass B
- smem  output  1  DataMem write strobe
- sdisplay  output  1  display latch strobe
- smemtoreg  output  1  0 = ALU result, 1 = memory data
- waiting_in  output  1  high in WAIT_IN
- err  output  1  sticky illegal-op/overflow flag
- state  output  3  current state (debug)

Behaviour:

Reset:
- Next edge with reset=1 → FETCH, err=0.
- Outputs: halt=1, all strobes 0, all selects 0.
- Reset overrides every state, including a mid-instruction state, WAIT_IN and HALTED.

States:
- FETCH=0: 1 cycle; synchronous InstMem read; → DECODE.
- DECODE=1: decode inst[31:26]/inst[5:0], register selects; → EXEC, or HALTED with err=1 on illegal opcode/funct.
- EXEC=2: smem pulses for sw; sdisplay pulses for out. lw → MEM; in → WAIT_IN; hlt → HALTED; otherwise → COMMIT.
- MEM=3: 1 cycle DataMem read latency; → COMMIT.
- WAIT_IN=4: hold until enter rising edge (IN_EDGE=1) or enter high (IN_EDGE=0); → COMMIT.
- COMMIT=5: halt=0 for exactly this cycle. sreg=1 for writing ops, unless add/sub/addi with of=1: then sreg=0, err=1, next → HALTED. Otherwise → FETCH.
- HALTED=6: halt=1, all strobes 0; exit only via reset.

Cycles per instruction:
- 4 for most instructions.
- 5 for lw.
- 4 + wait time for in.

Select/strobe timing:
- Selects are registered from decode and held stable from EXEC through COMMIT, so zero and the branch target stay valid when PC loads.
- Strobes are single-cycle.
- halt=1 in every state except COMMIT.

Decode:
- R-type (op 000000, funct):
  - 100000 add, 100010 sub, 100100 and, 100101 or, 100110 xor, 100111 nor, 101010 slt, 000000 sll, 000010 srl
  - smux5=0, smux32=0, sreg in COMMIT
  - 001000 jr: smuxPC=100, no write
- I-type (smux5=1, smux16=00, smux32=1):
  - 001000 addi, 001100 andi, 001101 ori, 001010 slti
  - 100011 lw: salu add, smemtoreg=1
  - 101011 sw: salu add, smem pulse in EXEC, no write
- Branches: 000100 beq (salu sub, smux32=0, smuxPC=001); 000101 bne (smuxPC=010).
- 000010 j: smuxPC=011.
- 011110 in: smux16=01, smux32=1, salu pass B, write rt.
- 011111 out: sdisplay pulse in EXEC.
- 111111 hlt.
- Anything else: illegal.

Edge detect:
- Reset clears enter_q.
- With IN_EDGE=1, enter already high on entry to WAIT_IN does not complete.

Test Plan:
- add r3,r1,r2 (0x00221820) after reset: states 0,1,2,5,0; smux5=0; salu=0000; sreg=1 and halt=0 only in cycle 4.
- lw r2,4(r1) (0x8C220004): 5 cycles; smemtoreg=1, smux32=1, salu=0000; sreg in MEM+1 cycle; no smem pulse.
- beq r1,r1,+3 then bne with zero=1: smuxPC=001 then 010, held EXEC through COMMIT; salu=0001; sreg=0.
- in r5 (0x78050000) with enter held high on entry: stays WAIT_IN, waiting_in=1; enter low→high → COMMIT next cycle; sreg=1, smux16=01, salu=1001.
- add with of=1 in COMMIT: sreg=0, err=1, → HALTED; halt stays 1 for 20 cycles; reset → FETCH, err=0.
- Illegal opcode 0xFC000000-0x04 (op 111110): DECODE → HALTED, err=1; reset asserted mid-EXEC of sw: smem=0 next cycle, state=FETCH.
